// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the iterative multiply/divide unit.
//   mdu_op_t    - operation code carried on op_e (6 and 7 are reserved)
//   mdu_state_t - control FSM states
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage issue bus and result bus of the MDU.
//   master (pipeline side): drives start_e/op_e/srca_e/srcb_e/abort,
//                           observes busy/done/div_zero/hi/lo
//   slave  (MDU side):      the reverse
interface mdu_if #(parameter int WIDTH = 32);
  import mdu_pkg::*;

  logic             start_e;
  mdu_op_t          op_e;
  logic [WIDTH-1:0] srca_e;
  logic [WIDTH-1:0] srcb_e;
  logic             abort;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start_e, op_e, srca_e, srcb_e, abort,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start_e, op_e, srca_e, srcb_e, abort,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational multiply or divide bit-step on the
// 2*WIDTH accumulator.
//   i_div - 1: restoring divide step, 0: shift-add multiply step
//   i_acc - accumulator in  ({hi_part, lo_part})
//   i_b   - multiplicand (multiply) or divisor (divide)
//   o_acc - accumulator out
// Multiply: lo_part holds the remaining multiplier bits, consumed LSB first;
//           the product shifts in from the top.
// Divide:   {rem, quot} shifts left; quotient bits enter at the bottom.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_ext;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_mul;
  logic [2*WIDTH-1:0] w_dvd;

  always_comb begin
    // carry out of the add is kept and shifted back into the top bit
    w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_b} : '0);
    w_mul = {w_sum, i_acc[WIDTH-1:1]};

    // shifted partial remainder needs WIDTH+1 bits before the compare
    w_ext = i_acc[2*WIDTH-1:WIDTH-1];
    w_ge  = (w_ext >= {1'b0, i_b});
    // result is < divisor, so modulo-2^WIDTH subtraction is exact
    w_rem = w_ge ? (w_ext[WIDTH-1:0] - i_b) : w_ext[WIDTH-1:0];
    w_dvd = {w_rem, i_acc[WIDTH-2:0], w_ge};

    o_acc = i_div ? w_dvd : w_mul;
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with architectural HI/LO.
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - mdu_if.slave: start_e/op_e/srca_e/srcb_e/abort in,
//           busy/done/div_zero/hi/lo out
// MULT/MULTU/DIV/DIVU run on magnitudes for WIDTH/UNROLL cycles, with the
// sign fixed up on the completion edge; MTHI/MTLO write in one cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int W2 = 2 * WIDTH;

  mdu_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_b, r_a_orig, r_hi, r_lo;
  logic             r_is_div, r_neg_q, r_neg_r, r_bz, r_done, r_dz;

  logic [W2-1:0]    w_chain [UNROLL+1];
  logic             w_arith, w_is_div, w_a_neg, w_b_neg, w_issue, w_last;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_q, w_r;
  logic [W2-1:0]    w_fin, w_prod;

  // issue decode
  always_comb begin
    w_arith  = (bus.op_e == MDU_MULT) || (bus.op_e == MDU_MULTU) ||
               (bus.op_e == MDU_DIV)  || (bus.op_e == MDU_DIVU);
    w_is_div = (bus.op_e == MDU_DIV)  || (bus.op_e == MDU_DIVU);
    w_a_neg  = ((bus.op_e == MDU_MULT) || (bus.op_e == MDU_DIV)) && bus.srca_e[WIDTH-1];
    w_b_neg  = ((bus.op_e == MDU_MULT) || (bus.op_e == MDU_DIV)) && bus.srcb_e[WIDTH-1];
    w_abs_a  = w_a_neg ? -bus.srca_e : bus.srca_e;
    w_abs_b  = w_b_neg ? -bus.srcb_e : bus.srcb_e;
    // abort beats a same-cycle start
    w_issue  = (r_state == IDLE) && bus.start_e && !bus.abort && w_arith;
    w_last   = (r_state == RUN) && (r_cnt == '0);
  end

  // UNROLL bit-steps chained per clock
  assign w_chain[0] = r_acc;
  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    mdu_step #(.WIDTH(WIDTH)) u_step (
      .i_div (r_is_div),
      .i_acc (w_chain[g]),
      .i_b   (r_b),
      .o_acc (w_chain[g+1])
    );
  end

  // sign fixup applied to the final step output on the completion edge
  always_comb begin
    w_fin  = w_chain[UNROLL];
    w_prod = r_neg_q ? -w_fin : w_fin;
    w_q    = r_neg_q ? -w_fin[WIDTH-1:0] : w_fin[WIDTH-1:0];
    w_r    = r_neg_r ? -w_fin[W2-1:WIDTH] : w_fin[W2-1:WIDTH];
  end

  // control FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_state_nxt = RUN;
      RUN:     if (bus.abort || w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // datapath and HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_a_orig <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bz     <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start_e && !bus.abort) begin
          if (bus.op_e == MDU_MTHI) r_hi <= bus.srca_e;
          if (bus.op_e == MDU_MTLO) r_lo <= bus.srca_e;
          if (w_arith) begin
            // multiplier (mul) or dividend (div) starts in the low half
            r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            r_b      <= w_is_div ? w_abs_b : w_abs_a;
            r_is_div <= w_is_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_bz     <= w_is_div && (bus.srcb_e == '0);
            r_a_orig <= bus.srca_e;
            r_cnt    <= CW'(N - 1);
          end
        end
      end else if (!bus.abort) begin
        r_acc <= w_fin;
        if (r_cnt == '0) begin
          r_done <= 1'b1;
          r_dz   <= r_bz;
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_bz) begin
            // divide by zero reports the raw dividend, not the fixed-up core result
            r_lo <= '1;
            r_hi <= r_a_orig;
          end else begin
            r_lo <= w_q;
            r_hi <= w_r;
          end
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign bus.busy     = (r_state == RUN);
  assign bus.done     = r_done;
  assign bus.div_zero = r_dz;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule
